keypad_event_decoder: RTL



---
 rtl/keypad_event_decoder_if.sv | 9 +
 rtl/keypad_event_decoder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/keypad_event_decoder_if.sv
// Valid/ready handshake carrying one decoded calculator key code.
interface keypad_event_decoder_if;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_event_decoder.sv
// Turns the interleaved keypad scanner index stream into single debounced
// press events (valid/ready), plus held-level, release-pulse and overrun status.
module keypad_event_decoder #(
  parameter int unsigned DEBOUNCE_HITS  = 8,
  parameter int unsigned RELEASE_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [5:0]                    indice_boton,
  keypad_event_decoder_if.master        key_if,
  output logic                          key_pressed,
  output logic                          key_release,
  output logic                          overrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [7:0] HITS_NEEDED = 8'(DEBOUNCE_HITS);
  localparam logic [7:0] MISS_LIMIT  = 8'(RELEASE_CYCLES);

  state_t     state, state_n;
  logic [5:0] cand, cand_n;
  logic [7:0] hits, hits_n;
  logic [7:0] miss, miss_n;
  logic       emit;
  logic       release_n;
  logic       sample_valid;
  logic [7:0] hits_inc;
  logic [7:0] miss_inc;

  // Row/column fields with bit 2 of the field set (none, error) are not keys.
  assign sample_valid = ~indice_boton[5] & ~indice_boton[2];
  assign hits_inc     = hits + 8'd1;
  assign miss_inc     = miss + 8'd1;
  assign key_pressed  = (state == HELD);

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Next-state, counter updates, emit and release decisions.
  always_comb begin
    state_n   = state;
    cand_n    = cand;
    hits_n    = hits;
    miss_n    = miss;
    emit      = 1'b0;
    release_n = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          state_n = DEBOUNCE;
          cand_n  = indice_boton;
          hits_n  = 8'd1;
          miss_n  = '0;
        end
      end
      DEBOUNCE: begin
        if (sample_valid) begin
          if (indice_boton == cand) begin
            hits_n = hits_inc;
          end else begin
            cand_n = indice_boton;
            hits_n = 8'd1;
          end
          miss_n = '0;
        end else begin
          miss_n = miss_inc;
          if (miss_inc == MISS_LIMIT) begin
            state_n = IDLE;
            hits_n  = '0;
            miss_n  = '0;
          end
        end
      end
      HELD: begin
        if (indice_boton == cand) begin
          miss_n = '0;
        end else begin
          miss_n = miss_inc;
          if (miss_inc == MISS_LIMIT) begin
            state_n   = IDLE;
            miss_n    = '0;
            release_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Acceptance is tested on the updated hit count from both IDLE and
    // DEBOUNCE, so a single required hit accepts on the first sighting.
    if (state != HELD && sample_valid && hits_n == HITS_NEEDED) begin
      state_n = HELD;
      emit    = 1'b1;
      hits_n  = '0;
      miss_n  = '0;
    end
  end

  // FSM state and debounce counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cand        <= '0;
      hits        <= '0;
      miss        <= '0;
      key_release <= 1'b0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      hits        <= hits_n;
      miss        <= miss_n;
      key_release <= release_n;
    end
  end

  // Event holding register: load, consume, or drop with sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_if.key_valid <= 1'b0;
      key_if.key_code  <= '0;
      overrun          <= 1'b0;
    end else if (emit) begin
      if (!key_if.key_valid || key_if.key_ready) begin
        key_if.key_valid <= 1'b1;
        key_if.key_code  <= key_map(indice_boton[1:0], indice_boton[4:3]);
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_if.key_ready) begin
      key_if.key_valid <= 1'b0;
    end
  end

endmodule
